// File: rtl/ula_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the sequential ALU.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    MULT   = 2'd1,
    DIVI   = 2'd2
  } estado_t;

  localparam int unsigned NUM_FLAGS = 4;
  localparam int unsigned FLAG_Z    = 3;
  localparam int unsigned FLAG_N    = 2;
  localparam int unsigned FLAG_C    = 1;
  localparam int unsigned FLAG_V    = 0;

endpackage

// File: rtl/ula_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// The *_next_c outputs are the register values after the current step.
module ula_muldiv #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo_next_c,
  output logic [W-1:0] hi_next_c,
  output logic         last_c
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  hi_q;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  opr_q;
  logic          mode_q;
  logic [CW-1:0] cnt_q;

  logic [W:0] sum_c;
  logic [W:0] shifted_c;
  logic [W:0] diff_c;

  // hi/lo hold {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    sum_c     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opr_q} : (W + 1)'(0));
    shifted_c = {hi_q, lo_q[W-1]};
    diff_c    = shifted_c - {1'b0, opr_q};
    if (mode_q) begin
      hi_next_c = diff_c[W] ? shifted_c[W-1:0] : diff_c[W-1:0];
      lo_next_c = {lo_q[W-2:0], ~diff_c[W]};
    end else begin
      hi_next_c = sum_c[W:1];
      lo_next_c = {sum_c[0], lo_q[W-1:1]};
    end
    last_c = step && (cnt_q == CW'(W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opr_q  <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= mode ? a : b;
      opr_q  <= mode ? b : a;
      mode_q <= mode;
      cnt_q  <= '0;
    end else if (step) begin
      hi_q  <= hi_next_c;
      lo_q  <= lo_next_c;
      cnt_q <= last_c ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/ula_sequencial.sv
// Sequential ALU: single-cycle ADD/SUB/logic, iterative unsigned MUL/DIV,
// registered results and {Z,N,C,V} flags held until the next completed op.
module ula_sequencial
  import ula_pkg::*;
#(
  parameter int unsigned Tamanho_Da_Palavra = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [2:0]                    op,
  input  logic [Tamanho_Da_Palavra-1:0] entradaTemp,
  input  logic [Tamanho_Da_Palavra-1:0] entradaAcc,
  output logic [Tamanho_Da_Palavra-1:0] resultado,
  output logic [Tamanho_Da_Palavra-1:0] resultadoAlto,
  output logic [NUM_FLAGS-1:0]          flags,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned W = Tamanho_Da_Palavra;

  estado_t        state_q, state_d;
  logic [W-1:0]   res_d, hi_d;
  logic [NUM_FLAGS-1:0] flags_d;
  logic           busy_d, done_d;

  logic           load_c, step_c, mode_c, last_c;
  logic [W-1:0]   lo_next_c, hi_next_c;

  logic [W:0]     sum_c, dif_c;
  logic [W-1:0]   alu_res_c;
  logic           alu_c_c, alu_v_c;
  logic           wr_c, c_c, v_c;

  ula_muldiv #(.W(W)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .step      (step_c),
    .mode      (mode_c),
    .a         (entradaTemp),
    .b         (entradaAcc),
    .lo_next_c (lo_next_c),
    .hi_next_c (hi_next_c),
    .last_c    (last_c)
  );

  // Single-cycle result and carry/overflow; dif_c[W] is the unsigned borrow
  always_comb begin
    sum_c     = {1'b0, entradaTemp} + {1'b0, entradaAcc};
    dif_c     = {1'b0, entradaTemp} - {1'b0, entradaAcc};
    alu_res_c = '0;
    alu_c_c   = 1'b0;
    alu_v_c   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res_c = sum_c[W-1:0];
        alu_c_c   = sum_c[W];
        alu_v_c   = (entradaTemp[W-1] == entradaAcc[W-1]) && (sum_c[W-1] != entradaTemp[W-1]);
      end
      OP_SUB: begin
        alu_res_c = dif_c[W-1:0];
        alu_c_c   = dif_c[W];
        alu_v_c   = (entradaTemp[W-1] != entradaAcc[W-1]) && (dif_c[W-1] != entradaTemp[W-1]);
      end
      OP_AND:  alu_res_c = entradaTemp & entradaAcc;
      OP_OR:   alu_res_c = entradaTemp | entradaAcc;
      OP_XOR:  alu_res_c = entradaTemp ^ entradaAcc;
      OP_NOT:  alu_res_c = ~entradaTemp;
      default: alu_res_c = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = resultado;
    hi_d    = resultadoAlto;
    flags_d = flags;
    busy_d  = busy;
    done_d  = 1'b0;
    load_c  = 1'b0;
    step_c  = 1'b0;
    mode_c  = (op == OP_DIV);
    wr_c    = 1'b0;
    c_c     = 1'b0;
    v_c     = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (start) begin
          if (op == OP_MUL) begin
            load_c  = 1'b1;
            busy_d  = 1'b1;
            state_d = MULT;
          end else if (op == OP_DIV && entradaAcc != '0) begin
            load_c  = 1'b1;
            busy_d  = 1'b1;
            state_d = DIVI;
          end else if (op == OP_DIV) begin
            // Divide by zero saturates the quotient and passes A through as remainder
            res_d  = '1;
            hi_d   = entradaTemp;
            v_c    = 1'b1;
            wr_c   = 1'b1;
            done_d = 1'b1;
          end else begin
            res_d  = alu_res_c;
            hi_d   = '0;
            c_c    = alu_c_c;
            v_c    = alu_v_c;
            wr_c   = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      MULT, DIVI: begin
        step_c = 1'b1;
        if (last_c) begin
          res_d   = lo_next_c;
          hi_d    = hi_next_c;
          c_c     = (state_q == MULT) && (hi_next_c != '0);
          wr_c    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase

    if (wr_c) begin
      flags_d[FLAG_Z] = (res_d == '0);
      flags_d[FLAG_N] = res_d[W-1];
      flags_d[FLAG_C] = c_c;
      flags_d[FLAG_V] = v_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= OCIOSO;
      resultado     <= '0;
      resultadoAlto <= '0;
      flags         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      resultado     <= res_d;
      resultadoAlto <= hi_d;
      flags         <= flags_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule

// File: tb/tb_ula_sequencial.sv
// Bench for ula_sequencial: directed vector table, hand sequences for
// back-to-back/reset corners, and random ops against an arithmetic model.
module tb_ula_sequencial;
  import ula_pkg::*;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] entradaTemp, entradaAcc;
  logic [W-1:0] resultado, resultadoAlto;
  logic [3:0]   flags;
  logic         busy, done;

  int total = 0;
  int bad   = 0;

  ula_sequencial #(.Tamanho_Da_Palavra(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .entradaTemp  (entradaTemp),
    .entradaAcc   (entradaAcc),
    .resultado    (resultado),
    .resultadoAlto(resultadoAlto),
    .flags        (flags),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  fl;
    bit          disturb;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sval(input logic [15:0] x);
    return x[15] ? int'(x) - 65536 : int'(x);
  endfunction

  // Reference model straight from the arithmetic definitions
  task automatic model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic [15:0] hi, output logic [3:0] fl,
                       output int lat);
    int s, u;
    logic [31:0] p;
    logic c, v;
    c = 0; v = 0; hi = 0; lat = 1;
    case (o)
      OP_ADD: begin
        u = int'(a) + int'(b); res = u[15:0]; c = (u > 65535);
        s = sval(a) + sval(b); v = (s > 32767) || (s < -32768);
      end
      OP_SUB: begin
        res = a - b; c = (a < b);
        s = sval(a) - sval(b); v = (s > 32767) || (s < -32768);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_MUL: begin
        p = 32'(a) * 32'(b); res = p[15:0]; hi = p[31:16]; c = (hi != 0); lat = W + 1;
      end
      default: begin
        if (b == 0) begin res = 16'hFFFF; hi = a; v = 1; end
        else begin res = a / b; hi = a % b; lat = W + 1; end
      end
    endcase
    fl = {res == 0, res[15], c, v};
  endtask

  // Issue one op; returns cycles until done and number of busy cycles seen
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input bit disturb, output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1; op = o; entradaTemp = a; entradaAcc = b;
    lat = 0; busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (busy) busy_cnt++;
      if (disturb && lat == 3) begin
        start = 1; op = OP_ADD; entradaTemp = '1; entradaAcc = '1;
      end else begin
        start = 0;
      end
    end
    start = 0;
    check("done_seen", 32'(done), 1);
  endtask

  task automatic verify(input string name, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] eres, input logic [15:0] ehi,
                        input logic [3:0] efl, input bit disturb);
    int lat, bc, elat;
    logic [15:0] mr, mh;
    logic [3:0] mf;
    model(o, a, b, mr, mh, mf, elat);
    run_op(o, a, b, disturb, lat, bc);
    check({name, "_res"}, 32'(resultado), 32'(eres));
    check({name, "_hi"}, 32'(resultadoAlto), 32'(ehi));
    check({name, "_flags"}, 32'(flags), 32'(efl));
    check({name, "_lat"}, 32'(lat), 32'(elat));
    check({name, "_busy"}, 32'(bc), (elat > 1) ? 32'(W) : 32'd0);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(done), 0);
    check({name, "_hold"}, 32'(resultado), 32'(eres));
  endtask

  vec_t vecs[$];

  initial begin
    logic [15:0] a, b, mr, mh;
    logic [2:0]  o;
    logic [3:0]  mf;
    int          elat, dcount;

    vecs.push_back('{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0101, 0});
    vecs.push_back('{OP_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0010, 1});
    vecs.push_back('{OP_DIV, 16'd1000, 16'd7,    16'h008E, 16'h0006, 4'b0000, 1});
    vecs.push_back('{OP_DIV, 16'h00AB, 16'h0000, 16'hFFFF, 16'h00AB, 4'b0101, 0});
    vecs.push_back('{OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 16'h0000, 4'b0100, 0});
    vecs.push_back('{OP_XOR, 16'hF0F0, 16'hFFFF, 16'h0F0F, 16'h0000, 4'b0000, 0});
    vecs.push_back('{OP_OR,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 0});
    vecs.push_back('{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001, 0});
    vecs.push_back('{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1010, 0});
    vecs.push_back('{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0010, 0});
    vecs.push_back('{OP_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 4'b0100, 0});

    rst = 1; start = 0; op = 0; entradaTemp = 0; entradaAcc = 0;
    repeat (2) @(negedge clk);
    check("reset_res", 32'(resultado), 0);
    check("reset_busy_done", {30'd0, busy, done}, 0);
    rst = 0;

    for (int i = 0; i < vecs.size(); i++)
      verify($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].hi, vecs[i].fl, vecs[i].disturb);

    // Back-to-back single-cycle ops: one result per cycle
    @(negedge clk);
    start = 1; op = OP_SUB; entradaTemp = 16'h0003; entradaAcc = 16'h0005;
    @(negedge clk);
    check("b2b_sub_done", 32'(done), 1);
    check("b2b_sub_res", 32'(resultado), 32'hFFFE);
    check("b2b_sub_flags", 32'(flags), 32'b0110);
    op = OP_AND; entradaTemp = 16'h0F0F; entradaAcc = 16'h00FF;
    @(negedge clk);
    start = 0;
    check("b2b_and_done", 32'(done), 1);
    check("b2b_and_res", 32'(resultado), 32'h000F);
    check("b2b_and_flags", 32'(flags), 0);
    @(negedge clk);
    check("b2b_done_drop", 32'(done), 0);

    // Async reset in the middle of a multiply
    @(negedge clk);
    start = 1; op = OP_MUL; entradaTemp = 16'h1234; entradaAcc = 16'h5678;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1;
    #1;
    check("rst_res", 32'(resultado), 0);
    check("rst_hi", 32'(resultadoAlto), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_busy_done", {30'd0, busy, done}, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("rst_abort_no_done", 32'(dcount), 0);
    verify("post_rst_add", OP_ADD, 16'd2, 16'd2, 16'd4, 16'd0, 4'b0000, 0);

    // Random ops against the model
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 15));
      model(o, a, b, mr, mh, mf, elat);
      verify($sformatf("rnd%0d_op%0d", i, o), o, a, b, mr, mh, mf, bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula_sequencial.md
Name: ula_sequencial

Overview:
- Arithmetic/logic unit directly downstream of the temp register. Operand A is the temp register's ALU output port; operand B is the accumulator.
- Single-cycle ops (ADD, SUB, logic) and multi-cycle unsigned MUL/DIV, using a start/busy/done handshake.
- Results and flags are registered and held until the next completed operation.

Parameters:
- Tamanho_Da_Palavra, 16, datapath width W (operands, results). Must be ≥ 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only in OCIOSO.
- op  in  3  opcode, latched with start.
- entradaTemp  in  W  operand A, fed by the temp register's ALU output.
- entradaAcc  in  W  operand B, from the accumulator.
- resultado  out  W  main result: sum/diff/logic, product low half, or quotient.
- resultadoAlto  out  W  product high half or remainder; 0 for all other ops.
- flags  out  4  {Z,N,C,V}, bits 3..0.
- busy  out  1  high while MUL/DIV iterates.
- done  out  1  one-cycle pulse when a result is written.

Behaviour:
- Reset (any time, async): state=OCIOSO; resultado, resultadoAlto, flags=0; busy=0, done=0; iteration counter=0. Reset mid-MUL/DIV aborts the operation; no done is produced.
- Opcodes: 000 ADD A+B; 001 SUB A−B; 010 AND; 011 OR; 100 XOR; 101 NOT A; 110 MUL unsigned; 111 DIV unsigned A/B.
- States: OCIOSO, MULT, DIVI.
  - OCIOSO with start=1 and op in 000..101: result and flags written at that edge; done=1 the following cycle; state stays OCIOSO. Back-to-back starts give one result per cycle.
  - OCIOSO with start=1 and op=110: latch A, B; counter=0; go to MULT; busy=1 next cycle.
  - OCIOSO with start=1 and op=111, B≠0: latch A, B; go to DIVI.
  - OCIOSO with start=1, op=111, B=0: single cycle. resultado=all ones, resultadoAlto=A, V=1, C=0; stays OCIOSO.
  - MULT: shift-add, one partial product per edge. DIVI: restoring division, one quotient bit per edge.
  - On the W-th edge in MULT/DIVI: write results and flags, return to OCIOSO, busy=0, done=1 next cycle.
  - Latency: start edge plus W iteration edges. done is seen W+1 cycles after the start edge.
- start while busy=1 is ignored: no queueing, no effect on the operation in flight. start in the done cycle is accepted normally.
- Operands are latched at start. Changes on entradaTemp/entradaAcc during busy have no effect.
- Flags:
  - Z = (resultado==0); N = resultado[W-1].
  - ADD: C = carry out of bit W-1; V = signed overflow.
  - SUB: C = borrow (A<B unsigned); V = signed overflow.
  - Logic ops: C=V=0.
  - MUL: C = (resultadoAlto≠0); V=0.
  - DIV: C=0; V=1 only for divide by zero.
- Outputs hold their values between operations. done is never high for more than one consecutive cycle per op.

Decomposition:
- Package ula_pkg: opcode localparams (OP_ADD..OP_DIV), state encoding (OCIOSO, MULT, DIVI), flag bit indices (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0).
- Sub-module ula_muldiv: iterative datapath (shift registers, partial remainder, counter) with load/step/mode inputs and a last-iteration output.
- Top level holds the FSM, single-cycle ops, and flag/result registers.

Test Plan (W=16):
- ADD A=0x7FFF, B=0x0001 → resultado=0x8000, flags Z0 N1 C0 V1, resultadoAlto=0, done one cycle after start.
- SUB A=0x0003, B=0x0005, then immediately AND A=0x0F0F, B=0x00FF → 0xFFFE (N1 C1 V0), then 0x000F (flags 0000) on consecutive cycles.
- MUL A=0x1234, B=0x0100 → resultado=0x3400, resultadoAlto=0x0012, C=1; busy for 16 cycles; done on cycle 17; start pulse during busy has no effect.
- DIV A=1000, B=7 → resultado=142 (0x008E), resultadoAlto=6; operands changed to 0xFFFF while busy → result unchanged.
- DIV A=0x00AB, B=0 → resultado=0xFFFF, resultadoAlto=0x00AB, V=1, busy stays 0, done one cycle after start.
- rst asserted asynchronously mid-clock at iteration 5 of MUL → all outputs 0 immediately, no done. After release, ADD 2+2 → 4, flags 0000.
